// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, flush and pause handling.
// Also keeps wrap-around performance counters for bubbles, flushes and holds.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             pause,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_reg_write,
  input  logic [3:0]       id_alu_op,
  input  logic [2:0]       id_load_ram_flag,
  input  logic [1:0]       id_store_ram_flag,
  input  logic [2:0]       id_branch_flag,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1_addr,
  output logic [4:0]       ex_rs2_addr,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic [3:0]       ex_alu_op,
  output logic [2:0]       ex_load_ram_flag,
  output logic [1:0]       ex_store_ram_flag,
  output logic [2:0]       ex_branch_flag,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            reg_write;
    logic [3:0]      alu_op;
    logic [2:0]      load_ram_flag;
    logic [1:0]      store_ram_flag;
    logic [2:0]      branch_flag;
  } ex_fields_t;

  ex_fields_t       ex_r, ex_nxt_s, id_fields_s;
  logic [CNT_W-1:0] bubble_cnt_r, bubble_cnt_nxt_s;
  logic [CNT_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
  logic [CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;

  // Assemble ID fields; a dead slot must never look like a load, store or write
  always_comb begin
    id_fields_s                = '0;
    id_fields_s.valid          = id_valid;
    id_fields_s.pc             = id_pc;
    id_fields_s.rs1_data       = id_rs1_data;
    id_fields_s.rs2_data       = id_rs2_data;
    id_fields_s.imm            = id_imm;
    id_fields_s.rs1_addr       = id_rs1_addr;
    id_fields_s.rs2_addr       = id_rs2_addr;
    id_fields_s.rd_addr        = id_rd_addr;
    id_fields_s.alu_op         = id_alu_op;
    if (id_valid) begin
      id_fields_s.reg_write      = id_reg_write;
      id_fields_s.load_ram_flag  = id_load_ram_flag;
      id_fields_s.store_ram_flag = id_store_ram_flag;
      id_fields_s.branch_flag    = id_branch_flag;
    end else begin
      id_fields_s.reg_write      = 1'b0;
      id_fields_s.load_ram_flag  = 3'b000;
      id_fields_s.store_ram_flag = 2'b00;
      id_fields_s.branch_flag    = 3'b000;
    end
  end

  // Next-state selection: hold beats flush beats pause beats capture
  always_comb begin
    ex_nxt_s         = ex_r;
    bubble_cnt_nxt_s = bubble_cnt_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    hold_cnt_nxt_s   = hold_cnt_r;
    if (hold) begin
      hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
    end else if (flush) begin
      ex_nxt_s        = '0;
      flush_cnt_nxt_s = flush_cnt_r + CNT_W'(1);
    end else if (pause) begin
      ex_nxt_s         = '0;
      bubble_cnt_nxt_s = bubble_cnt_r + CNT_W'(1);
    end else begin
      ex_nxt_s = id_fields_s;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r         <= '0;
      bubble_cnt_r <= '0;
      flush_cnt_r  <= '0;
      hold_cnt_r   <= '0;
    end else begin
      ex_r         <= ex_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
    end
  end

  assign ex_valid          = ex_r.valid;
  assign ex_pc             = ex_r.pc;
  assign ex_rs1_data       = ex_r.rs1_data;
  assign ex_rs2_data       = ex_r.rs2_data;
  assign ex_imm            = ex_r.imm;
  assign ex_rs1_addr       = ex_r.rs1_addr;
  assign ex_rs2_addr       = ex_r.rs2_addr;
  assign ex_rd_addr        = ex_r.rd_addr;
  assign ex_reg_write      = ex_r.reg_write;
  assign ex_alu_op         = ex_r.alu_op;
  assign ex_load_ram_flag  = ex_r.load_ram_flag;
  assign ex_store_ram_flag = ex_r.store_ram_flag;
  assign ex_branch_flag    = ex_r.branch_flag;
  assign bubble_cnt        = bubble_cnt_r;
  assign flush_cnt         = flush_cnt_r;
  assign hold_cnt          = hold_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg; a second instance with 4-bit counters
// exercises counter wrap-around.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst, hold, flush, pause, id_valid, id_reg_write;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0] id_alu_op;
  logic [2:0] id_load_ram_flag, id_branch_flag;
  logic [1:0] id_store_ram_flag;

  logic ex_valid, ex_reg_write;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0] ex_alu_op;
  logic [2:0] ex_load_ram_flag, ex_branch_flag;
  logic [1:0] ex_store_ram_flag;
  logic [31:0] bubble_cnt, flush_cnt, hold_cnt;

  logic s_valid, s_reg_write;
  logic [XLEN-1:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0] s_rs1_addr, s_rs2_addr, s_rd_addr;
  logic [3:0] s_alu_op;
  logic [2:0] s_load, s_branch;
  logic [1:0] s_store;
  logic [3:0] s_bubble_cnt, s_flush_cnt, s_hold_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .pause(pause),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .id_load_ram_flag(id_load_ram_flag),
    .id_store_ram_flag(id_store_ram_flag), .id_branch_flag(id_branch_flag),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_load_ram_flag(ex_load_ram_flag),
    .ex_store_ram_flag(ex_store_ram_flag), .ex_branch_flag(ex_branch_flag),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
  );

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .pause(pause),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_alu_op(id_alu_op), .id_load_ram_flag(id_load_ram_flag),
    .id_store_ram_flag(id_store_ram_flag), .id_branch_flag(id_branch_flag),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1_addr(s_rs1_addr),
    .ex_rs2_addr(s_rs2_addr), .ex_rd_addr(s_rd_addr), .ex_reg_write(s_reg_write),
    .ex_alu_op(s_alu_op), .ex_load_ram_flag(s_load),
    .ex_store_ram_flag(s_store), .ex_branch_flag(s_branch),
    .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt), .hold_cnt(s_hold_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic [2:0] ld, input logic [1:0] st, input logic vld);
    id_valid = vld;
    id_pc = pc;
    id_rs1_data = pc + 32'h0000_1000;
    id_rs2_data = pc + 32'h0000_2000;
    id_imm = pc + 32'h0000_0004;
    id_rs1_addr = rs1;
    id_rs2_addr = 5'd2;
    id_rd_addr = rd;
    id_reg_write = 1'b1;
    id_alu_op = 4'd3;
    id_load_ram_flag = ld;
    id_store_ram_flag = st;
    id_branch_flag = 3'b000;
  endtask

  initial begin
    hold = 1'b0; flush = 1'b0; pause = 1'b0;
    // Reset with busy ID inputs
    drive_id(32'hDEAD_BEE0, 5'd9, 5'd10, 3'b010, 2'b01, 1'b1);
    id_branch_flag = 3'b101;
    rst = 1'b1;
    step(); step();
    check("rst_valid", ex_valid, 1'b0);
    check("rst_pc", ex_pc, 32'h0);
    check("rst_rs1_data", ex_rs1_data, 32'h0);
    check("rst_rd", ex_rd_addr, 5'd0);
    check("rst_load", ex_load_ram_flag, 3'b000);
    check("rst_branch", ex_branch_flag, 3'b000);
    check("rst_cnts", {bubble_cnt, flush_cnt} | {32'h0, hold_cnt}, 64'h0);

    // First capture after reset
    rst = 1'b0;
    drive_id(32'h100, 5'd1, 5'd3, 3'b000, 2'b00, 1'b1);
    step();
    check("cap_pc", ex_pc, 32'h100);
    check("cap_valid", ex_valid, 1'b1);
    check("cap_rs2_data", ex_rs2_data, 32'h2100);
    check("cap_imm", ex_imm, 32'h104);
    check("cap_alu", ex_alu_op, 4'd3);
    check("cap_rw", ex_reg_write, 1'b1);

    // Load-use: load enters EX, dependent stalls one cycle
    drive_id(32'h104, 5'd1, 5'd5, 3'b010, 2'b00, 1'b1);
    step();
    check("ld_flag", ex_load_ram_flag, 3'b010);
    check("ld_rd", ex_rd_addr, 5'd5);
    drive_id(32'h108, 5'd5, 5'd6, 3'b000, 2'b00, 1'b1);
    pause = 1'b1;
    step();
    check("bub_valid", ex_valid, 1'b0);
    check("bub_load", ex_load_ram_flag, 3'b000);
    check("bub_rd", ex_rd_addr, 5'd0);
    check("bub_pc", ex_pc, 32'h0);
    check("bub_cnt1", bubble_cnt, 32'd1);
    pause = 1'b0;
    step();
    check("dep_pc", ex_pc, 32'h108);
    check("dep_rs1", ex_rs1_addr, 5'd5);
    check("dep_valid", ex_valid, 1'b1);
    check("dep_bub_cnt", bubble_cnt, 32'd1);

    // Flush and pause together: flush wins
    flush = 1'b1; pause = 1'b1;
    step();
    check("fp_valid", ex_valid, 1'b0);
    check("fp_flush_cnt", flush_cnt, 32'd1);
    check("fp_bub_cnt", bubble_cnt, 32'd1);

    // Hold with flush pending and changing ID
    flush = 1'b0; pause = 1'b0;
    drive_id(32'h200, 5'd4, 5'd8, 3'b000, 2'b00, 1'b1);
    step();
    check("h_pre_pc", ex_pc, 32'h200);
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_id(32'h300 + 32'(i * 4), 5'd7, 5'd9, 3'b001, 2'b00, 1'b1);
      step();
      check("h_pc", ex_pc, 32'h200);
    end
    check("h_cnt", hold_cnt, 32'd5);
    check("h_flush_cnt", flush_cnt, 32'd1);
    check("h_rd", ex_rd_addr, 5'd8);
    hold = 1'b0;
    step();
    check("hf_valid", ex_valid, 1'b0);
    check("hf_pc", ex_pc, 32'h0);
    check("hf_flush_cnt", flush_cnt, 32'd2);
    check("hf_hold_cnt", hold_cnt, 32'd5);

    // Invalid slot never carries load/store
    flush = 1'b0;
    drive_id(32'h400, 5'd1, 5'd7, 3'b001, 2'b01, 1'b0);
    step();
    check("inv_valid", ex_valid, 1'b0);
    check("inv_load", ex_load_ram_flag, 3'b000);
    check("inv_store", ex_store_ram_flag, 2'b00);
    check("inv_rw", ex_reg_write, 1'b0);
    check("inv_pc", ex_pc, 32'h400);

    // Reset mid-stall leaves a bubble
    drive_id(32'h500, 5'd1, 5'd7, 3'b010, 2'b00, 1'b1);
    step();
    hold = 1'b1; rst = 1'b1;
    step();
    check("rsth_valid", ex_valid, 1'b0);
    check("rsth_load", ex_load_ram_flag, 3'b000);
    check("rsth_hold_cnt", hold_cnt, 32'd0);

    // Counter wrap: 17 pauses on a 4-bit counter reads 1
    hold = 1'b0; rst = 1'b0; pause = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check("wrap_small", s_bubble_cnt, 4'd1);
    check("wrap_big", bubble_cnt, 32'd17);
    check("wrap_small_valid", s_valid, 1'b0);
    pause = 1'b0;
    step();
    check("post_wrap_pc", s_pc, 32'h500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
